// File: rtl/qmult_pipe.sv
// Three-stage pipelined signed Q-format multiplier with rounding, saturation
// and a sticky overflow flag. One global advance enable stalls the whole pipe.
module qmult_pipe #(
   parameter int Q = 18,
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         round_en,
   input  logic         sat_en,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] o_result,
   output logic         ovr,
   output logic         ovr_sticky,
   input  logic         clr
);

   localparam logic [2*N-1:0] ONE_W    = {{(2*N-1){1'b0}}, 1'b1};
   localparam logic [2*N-1:0] RND_HALF = ONE_W << (Q-1);
   localparam logic [2*N-1:0] LIM_POS  = {{(N+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic [2*N-1:0] LIM_NEG  = LIM_POS + ONE_W;
   localparam logic [N-1:0]   SAT_POS  = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0]   SAT_NEG  = {1'b1, {(N-1){1'b0}}};

   // stage 1: sign and exact magnitudes
   logic         r_v1;
   logic         r_sign1;
   logic [N:0]   r_mag_a;
   logic [N:0]   r_mag_b;
   logic         r_rnd1;
   logic         r_sat1;

   // stage 2: unsigned magnitude product
   logic         r_v2;
   logic         r_sign2;
   logic [2*N-1:0] r_p;
   logic         r_rnd2;
   logic         r_sat2;

   // stage 3: final result
   logic         r_v3;
   logic [N-1:0] r_res;
   logic         r_ovr;
   logic         r_sticky;

   logic         w_en;
   logic [N:0]   w_a_ext;
   logic [N:0]   w_b_ext;
   logic [N:0]   w_mag_a;
   logic [N:0]   w_mag_b;
   logic [2*N-1:0] w_prod;
   logic [2*N-1:0] w_sum;
   logic [2*N-1:0] w_m;
   logic [N-1:0] w_m_low;
   logic         w_neg;
   logic         w_ovf;
   logic [N-1:0] w_res;

   assign w_en = !r_v3 || out_ready;

   // Sign-extend one bit so |-2^(N-1)| is representable.
   assign w_a_ext = {a[N-1], a};
   assign w_b_ext = {b[N-1], b};
   assign w_mag_a = a[N-1] ? (~w_a_ext + 1'b1) : w_a_ext;
   assign w_mag_b = b[N-1] ? (~w_b_ext + 1'b1) : w_b_ext;

   assign w_prod = {{(N-1){1'b0}}, r_mag_a} * {{(N-1){1'b0}}, r_mag_b};

   // Adding half an LSB before the shift equals (P >> Q) + P[Q-1].
   assign w_sum   = r_p + (r_rnd2 ? RND_HALF : '0);
   assign w_m     = w_sum >> Q;
   assign w_m_low = w_m[N-1:0];

   // NOTE: every variable gets a default first so no path can infer a latch.
   always_comb begin
      w_neg = r_sign2 && (w_m != '0);
      w_ovf = 1'b0;
      w_res = w_neg ? (~w_m_low + 1'b1) : w_m_low;
      if (w_neg) begin
         w_ovf = (w_m > LIM_NEG);
      end else begin
         w_ovf = (w_m > LIM_POS);
      end
      if (w_ovf && r_sat2) begin
         w_res = w_neg ? SAT_NEG : SAT_POS;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // stage reads the values its neighbours held before this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1  <= 1'b0;
         r_v2  <= 1'b0;
         r_v3  <= 1'b0;
         r_res <= '0;
         r_ovr <= 1'b0;
      end else if (w_en) begin
         r_v1  <= in_valid;
         r_v2  <= r_v1;
         r_v3  <= r_v2;
         r_res <= w_res;
         r_ovr <= w_ovf;
      end
   end

   // NOTE: datapath registers carry no reset; the valid bits alone decide
   // whether their contents mean anything.
   always_ff @(posedge clk) begin
      if (w_en) begin
         r_sign1 <= a[N-1] ^ b[N-1];
         r_mag_a <= w_mag_a;
         r_mag_b <= w_mag_b;
         r_rnd1  <= round_en;
         r_sat1  <= sat_en;
         r_sign2 <= r_sign1;
         r_p     <= w_prod;
         r_rnd2  <= r_rnd1;
         r_sat2  <= r_sat1;
      end
   end

   // A delivered overflow beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sticky <= 1'b0;
      end else if (r_v3 && out_ready && r_ovr) begin
         r_sticky <= 1'b1;
      end else if (clr) begin
         r_sticky <= 1'b0;
      end
   end

   // Outputs are forced to their idle values for the whole time rst is high.
   assign in_ready   = rst || w_en;
   assign out_valid  = r_v3 && !rst;
   assign o_result   = rst ? '0 : r_res;
   assign ovr        = r_ovr && !rst;
   assign ovr_sticky = r_sticky && !rst;

endmodule
